// File: rtl/id_operand_stage_pkg.sv
// rtl/id_operand_stage_pkg.sv - shared pipeline widths, constants and ID/EXE control bundle
package id_operand_stage_pkg;

   localparam int ALUC_W = 4;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic wreg;
      logic m2reg;
      logic wmem;
      logic aluimm;
   } ectrl_t;

   localparam int ECTRL_W = $bits(ectrl_t);

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// rtl/id_operand_stage_fwd_mux.sv - per-operand forwarding priority selector
module fwd_mux
   import id_operand_stage_pkg::*;
#(
   parameter bit FWD_WB = 1'b1
) (
   input  logic [REG_W-1:0]  src,
   input  logic [DATA_W-1:0] rf_d,
   input  logic              exe_wreg,
   input  logic              exe_m2reg,
   input  logic [REG_W-1:0]  exe_rn,
   input  logic [DATA_W-1:0] exe_alu,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [REG_W-1:0]  mem_rn,
   input  logic [DATA_W-1:0] mem_alu,
   input  logic [DATA_W-1:0] mem_mdata,
   input  logic              wb_wreg,
   input  logic [REG_W-1:0]  wb_rn,
   input  logic [DATA_W-1:0] wb_d,
   output logic [DATA_W-1:0] opnd
);

   logic exe_hit, mem_hit, wb_hit;

   // A load still in EXE has no data yet; the hazard logic stalls instead.
   assign exe_hit = exe_wreg && !exe_m2reg && (exe_rn != REG_ZERO) && (exe_rn == src);
   assign mem_hit = mem_wreg && (mem_rn != REG_ZERO) && (mem_rn == src);
   assign wb_hit  = FWD_WB && wb_wreg && (wb_rn != REG_ZERO) && (wb_rn == src);

   always_comb begin
      opnd = rf_d;
      if (exe_hit)
         opnd = exe_alu;
      else if (mem_hit)
         opnd = mem_m2reg ? mem_mdata : mem_alu;
      else if (wb_hit)
         opnd = wb_d;
   end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID operand resolution, load-use stall and ID/EXE register
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter bit FWD_WB = 1'b1
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              id_valid,
   input  logic              id_flush,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_W-1:0]  id_rn,
   input  logic              id_wreg,
   input  logic              id_m2reg,
   input  logic              id_wmem,
   input  logic              id_aluimm,
   input  logic [ALUC_W-1:0] id_aluc,
   input  logic [DATA_W-1:0] id_imm,
   output logic [REG_W-1:0]  rna,
   output logic [REG_W-1:0]  rnb,
   input  logic [DATA_W-1:0] qa,
   input  logic [DATA_W-1:0] qb,
   input  logic              exe_wreg,
   input  logic              exe_m2reg,
   input  logic [REG_W-1:0]  exe_rn,
   input  logic [DATA_W-1:0] exe_alu,
   input  logic              mem_wreg,
   input  logic              mem_m2reg,
   input  logic [REG_W-1:0]  mem_rn,
   input  logic [DATA_W-1:0] mem_alu,
   input  logic [DATA_W-1:0] mem_mdata,
   input  logic              wb_wreg,
   input  logic [REG_W-1:0]  wb_rn,
   input  logic [DATA_W-1:0] wb_d,
   output logic              stall,
   output logic [DATA_W-1:0] ea,
   output logic [DATA_W-1:0] eb,
   output logic [DATA_W-1:0] eimm,
   output logic [REG_W-1:0]  ern,
   output logic [ALUC_W-1:0] ealuc,
   output logic              ewreg,
   output logic              em2reg,
   output logic              ewmem,
   output logic              ealuimm,
   output logic              evalid,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DATA_W-1:0] opa, opb;
   logic              hazard, advance;
   ectrl_t            ectrl;

   assign rna = id_rs;
   assign rnb = id_rt;

   fwd_mux #(.FWD_WB(FWD_WB)) u_fwd_a (
      .src(id_rs), .rf_d(qa),
      .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .exe_alu(exe_alu),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata),
      .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
      .opnd(opa)
   );

   fwd_mux #(.FWD_WB(FWD_WB)) u_fwd_b (
      .src(id_rt), .rf_d(qb),
      .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .exe_alu(exe_alu),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata),
      .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
      .opnd(opb)
   );

   assign hazard = id_valid && exe_wreg && exe_m2reg && (exe_rn != REG_ZERO) &&
                   ((id_use_rs && (exe_rn == id_rs)) || (id_use_rt && (exe_rn == id_rt)));

   // A flushed instruction is discarded anyway, so it must not hold the front end.
   assign stall   = hazard && !id_flush;
   assign advance = !stall && !id_flush && id_valid;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ea        <= '0;
         eb        <= '0;
         eimm      <= '0;
         ern       <= '0;
         ealuc     <= '0;
         ectrl     <= '0;
         evalid    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (advance) begin
            ea     <= opa;
            eb     <= opb;
            eimm   <= id_imm;
            ern    <= id_rn;
            ealuc  <= id_aluc;
            ectrl  <= '{wreg: id_wreg, m2reg: id_m2reg, wmem: id_wmem, aluimm: id_aluimm};
            evalid <= 1'b1;
         end else begin
            ea     <= '0;
            eb     <= '0;
            eimm   <= '0;
            ern    <= '0;
            ealuc  <= '0;
            ectrl  <= '0;
            evalid <= 1'b0;
         end
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign ewreg   = ectrl.wreg;
   assign em2reg  = ectrl.m2reg;
   assign ewmem   = ectrl.wmem;
   assign ealuimm = ectrl.aluimm;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - self-checking bench for id_operand_stage
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        clrn;
   logic        id_valid, id_flush, id_use_rs, id_use_rt;
   logic [4:0]  id_rs, id_rt, id_rn;
   logic        id_wreg, id_m2reg, id_wmem, id_aluimm;
   logic [3:0]  id_aluc;
   logic [31:0] id_imm;
   logic [4:0]  rna, rnb;
   logic [31:0] qa, qb;
   logic        exe_wreg, exe_m2reg;
   logic [4:0]  exe_rn;
   logic [31:0] exe_alu;
   logic        mem_wreg, mem_m2reg;
   logic [4:0]  mem_rn;
   logic [31:0] mem_alu, mem_mdata;
   logic        wb_wreg;
   logic [4:0]  wb_rn;
   logic [31:0] wb_d;
   logic        stall;
   logic [31:0] ea, eb, eimm;
   logic [4:0]  ern;
   logic [3:0]  ealuc;
   logic        ewreg, em2reg, ewmem, ealuimm, evalid;
   logic [15:0] stall_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_operand_stage #(.FWD_WB(1'b1)) dut (
      .clk(clk), .clrn(clrn),
      .id_valid(id_valid), .id_flush(id_flush),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
      .id_aluimm(id_aluimm), .id_aluc(id_aluc), .id_imm(id_imm),
      .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
      .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .exe_alu(exe_alu),
      .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
      .mem_alu(mem_alu), .mem_mdata(mem_mdata),
      .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
      .stall(stall), .ea(ea), .eb(eb), .eimm(eimm), .ern(ern), .ealuc(ealuc),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
      .evalid(evalid), .stall_cnt(stall_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Producers listed youngest first; a load in EXE cannot supply data.
   function automatic logic [31:0] m_resolve(input logic [4:0] src, input logic [31:0] rf);
      logic        ok  [3];
      logic [4:0]  rn  [3];
      logic [31:0] val [3];
      logic [31:0] r;
      logic        found;
      ok[0] = exe_wreg && !exe_m2reg; rn[0] = exe_rn; val[0] = exe_alu;
      ok[1] = mem_wreg;               rn[1] = mem_rn; val[1] = mem_m2reg ? mem_mdata : mem_alu;
      ok[2] = wb_wreg;                rn[2] = wb_rn;  val[2] = wb_d;
      r = rf;
      found = 1'b0;
      for (int i = 0; i < 3; i++)
         if (!found && ok[i] && rn[i] != 5'd0 && rn[i] == src) begin
            r = val[i];
            found = 1'b1;
         end
      return r;
   endfunction

   function automatic logic m_stall();
      logic load_in_exe, dep;
      load_in_exe = exe_wreg && exe_m2reg && exe_rn != 5'd0;
      dep = (id_use_rs && exe_rn == id_rs) || (id_use_rt && exe_rn == id_rt);
      return id_valid && load_in_exe && dep && !id_flush;
   endfunction

   logic        m_valid = 1'b0;
   logic        m_wreg, m_m2reg, m_wmem, m_aluimm;
   logic [31:0] m_ea, m_eb, m_imm;
   logic [4:0]  m_rn;
   logic [3:0]  m_aluc;
   int          m_cnt = 0;

   always begin
      @(negedge clk);
      check("cmb_stall", {31'd0, stall}, {31'd0, m_stall()});
      check("cmb_rna", {27'd0, rna}, {27'd0, id_rs});
      check("cmb_rnb", {27'd0, rnb}, {27'd0, id_rt});
      @(posedge clk);
      if (!clrn) begin
         m_valid = 1'b0;
         m_cnt   = 0;
      end else begin
         if (m_stall() && m_cnt < 65535) m_cnt++;
         m_valid = !m_stall() && !id_flush && id_valid;
         m_ea = m_resolve(id_rs, qa);
         m_eb = m_resolve(id_rt, qb);
         m_imm = id_imm; m_rn = id_rn; m_aluc = id_aluc;
         m_wreg = id_wreg; m_m2reg = id_m2reg; m_wmem = id_wmem; m_aluimm = id_aluimm;
      end
      #1;
      check("cmp_evalid", {31'd0, evalid}, {31'd0, m_valid});
      check("cmp_ewreg", {31'd0, ewreg}, {31'd0, m_valid && m_wreg});
      check("cmp_em2reg", {31'd0, em2reg}, {31'd0, m_valid && m_m2reg});
      check("cmp_ewmem", {31'd0, ewmem}, {31'd0, m_valid && m_wmem});
      check("cmp_cnt", {16'd0, stall_cnt}, m_cnt);
      if (m_valid) begin
         check("cmp_ea", ea, m_ea);
         check("cmp_eb", eb, m_eb);
         check("cmp_eimm", eimm, m_imm);
         check("cmp_ern", {27'd0, ern}, {27'd0, m_rn});
         check("cmp_ealuc", {28'd0, ealuc}, {28'd0, m_aluc});
         check("cmp_ealuimm", {31'd0, ealuimm}, {31'd0, m_aluimm});
      end
   end

   task automatic idle();
      id_valid = 0; id_flush = 0; id_use_rs = 0; id_use_rt = 0;
      id_rs = 0; id_rt = 0; id_rn = 0;
      id_wreg = 0; id_m2reg = 0; id_wmem = 0; id_aluimm = 0; id_aluc = 0; id_imm = 0;
      qa = 0; qb = 0;
      exe_wreg = 0; exe_m2reg = 0; exe_rn = 0; exe_alu = 0;
      mem_wreg = 0; mem_m2reg = 0; mem_rn = 0; mem_alu = 0; mem_mdata = 0;
      wb_wreg = 0; wb_rn = 0; wb_d = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rn = rn;
      id_use_rs = 1; id_use_rt = 1;
      id_wreg = 1; id_aluc = 4'h3; id_imm = 32'h0000_0040 + rn;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_evalid"}, {31'd0, evalid}, 32'd0);
      check({tag, "_ewreg"}, {31'd0, ewreg}, 32'd0);
      check({tag, "_ea"}, ea, 32'd0);
      check({tag, "_eb"}, eb, 32'd0);
      check({tag, "_eimm"}, eimm, 32'd0);
      check({tag, "_cnt"}, {16'd0, stall_cnt}, 32'd0);
   endtask

   initial begin
      clrn = 1'b1;
      idle();
      #1 clrn = 1'b0;
      #1 check_reset_state("rst0");
      step(); step();
      clrn = 1'b1;
      step();

      // EXE forward
      instr(5'd5, 5'd6, 5'd9);
      qa = 32'hDEAD; qb = 32'h0000_0066;
      exe_wreg = 1; exe_rn = 5'd5; exe_alu = 32'h1234;
      #1 check("exefwd_stall", {31'd0, stall}, 32'd0);
      step();
      check("exefwd_ea", ea, 32'h1234);
      check("exefwd_eb", eb, 32'h66);
      check("exefwd_evalid", {31'd0, evalid}, 32'd1);

      // load-use: one bubble, then MEM load data forwards
      idle();
      instr(5'd1, 5'd3, 5'd10);
      qb = 32'hBAD0;
      exe_wreg = 1; exe_m2reg = 1; exe_rn = 5'd3; exe_alu = 32'h0000_0100;
      #1 check("lu_stall", {31'd0, stall}, 32'd1);
      step();
      check("lu_evalid", {31'd0, evalid}, 32'd0);
      check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
      exe_wreg = 0; exe_m2reg = 0; exe_rn = 0;
      mem_wreg = 1; mem_m2reg = 1; mem_rn = 5'd3; mem_alu = 32'h0000_0100; mem_mdata = 32'h55;
      #1 check("lu2_stall", {31'd0, stall}, 32'd0);
      step();
      check("lu2_eb", eb, 32'h55);
      check("lu2_evalid", {31'd0, evalid}, 32'd1);
      check("lu2_cnt", {16'd0, stall_cnt}, 32'd1);

      // priority: EXE over MEM over WB
      idle();
      instr(5'd7, 5'd7, 5'd11);
      qa = 32'hAAAA; qb = 32'hBBBB;
      exe_wreg = 1; exe_rn = 7; exe_alu = 1;
      mem_wreg = 1; mem_rn = 7; mem_alu = 2;
      wb_wreg = 1; wb_rn = 7; wb_d = 3;
      step();
      check("prio_exe_ea", ea, 32'd1);
      check("prio_exe_eb", eb, 32'd1);
      exe_wreg = 0;
      step();
      check("prio_mem_ea", ea, 32'd2);
      mem_wreg = 0;
      step();
      check("prio_wb_ea", ea, 32'd3);

      // register 0 never forwards
      idle();
      instr(5'd0, 5'd0, 5'd12);
      exe_wreg = 1; exe_rn = 0; exe_alu = 32'h11;
      mem_wreg = 1; mem_rn = 0; mem_alu = 32'h22;
      wb_wreg = 1; wb_rn = 0; wb_d = 32'h33;
      step();
      check("r0_ea", ea, 32'd0);
      check("r0_eb", eb, 32'd0);

      // flush beats hazard
      idle();
      instr(5'd4, 5'd2, 5'd13);
      exe_wreg = 1; exe_m2reg = 1; exe_rn = 5'd4;
      id_flush = 1;
      #1 check("fl_stall", {31'd0, stall}, 32'd0);
      step();
      check("fl_evalid", {31'd0, evalid}, 32'd0);
      check("fl_ewreg", {31'd0, ewreg}, 32'd0);
      check("fl_cnt", {16'd0, stall_cnt}, 32'd1);

      // invalid ID slot does not stall
      id_flush = 0; id_valid = 0;
      #1 check("inv_stall", {31'd0, stall}, 32'd0);
      step();

      // reset mid-stall; stall stays combinational during reset
      idle();
      instr(5'd8, 5'd8, 5'd14);
      qa = 32'h77;
      step();
      check("pre_rst_evalid", {31'd0, evalid}, 32'd1);
      exe_wreg = 1; exe_m2reg = 1; exe_rn = 5'd8;
      clrn = 1'b0;
      #1 check_reset_state("rst1");
      check("rst1_stall", {31'd0, stall}, 32'd1);
      step();
      clrn = 1'b1;
      step();
      check("post_rst_evalid", {31'd0, evalid}, 32'd0);
      check("post_rst_cnt", {16'd0, stall_cnt}, 32'd1);

      // saturation
      repeat (70000) step();
      check("sat_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
      repeat (5) step();
      check("sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);

      idle();
      step(); step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
